// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer at the head of the fetch stage.
// It owns the PC and picks the next fetch address from the sequential
// increment, a jump target, a return target, or a vector word read from
// memory. Reset boot and interrupt entry each take two cycles because the
// vector read port returns its data one cycle after the strobe.
module pc_seq #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned RESET_VEC_ADDR = 0,
  parameter int unsigned IRQ_VEC_ADDR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              ret_en,
  input  logic [ADDR_W-1:0] ret_target,
  input  logic              irq,
  output logic              irq_ack,
  output logic              irq_push,
  output logic [ADDR_W-1:0] irq_ret_addr,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [ADDR_W-1:0] vec_data,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush
);

  localparam logic [ADDR_W-1:0] RST_VEC = ADDR_W'(RESET_VEC_ADDR);
  localparam logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'(IRQ_VEC_ADDR);

  // BOOT/IRQ_WAIT bracket the one-cycle vector read latency.
  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    BOOT_WAIT = 2'd1,
    RUN       = 2'd2,
    IRQ_WAIT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic [ADDR_W-1:0] npc;

  // Redirect candidate: return beats jump, otherwise fall through (wraps).
  always_comb begin
    if (ret_en) begin
      npc = ret_target;
    end else if (jmp_en) begin
      npc = jmp_target;
    end else begin
      npc = pc_q + ADDR_W'(1);
    end
  end

  // Next-state, next-PC and all combinational outputs.
  always_comb begin
    // NOTE: every output and _d signal gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    pc_d       = pc_q;
    ret_addr_d = ret_addr_q;
    vec_rd     = 1'b0;
    vec_addr   = RST_VEC;
    pc_valid   = 1'b0;
    flush      = 1'b0;
    irq_ack    = 1'b0;
    irq_push   = 1'b0;

    unique case (state_q)
      BOOT: begin
        vec_rd  = 1'b1;
        state_d = BOOT_WAIT;
      end
      BOOT_WAIT: begin
        pc_d    = vec_data;
        state_d = RUN;
      end
      RUN: begin
        pc_valid = 1'b1;
        // A stalled cycle ignores redirects and interrupts; upstream holds them.
        if (!stall) begin
          if (irq) begin
            // Interrupt wins over any redirect, which becomes the return address.
            irq_ack    = 1'b1;
            irq_push   = 1'b1;
            ret_addr_d = npc;
            flush      = 1'b1;
            vec_rd     = 1'b1;
            vec_addr   = IRQ_VEC;
            state_d    = IRQ_WAIT;
          end else begin
            pc_d  = npc;
            flush = ret_en | jmp_en;
          end
        end
      end
      IRQ_WAIT: begin
        pc_d    = vec_data;
        flush   = 1'b1;
        state_d = RUN;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC and saved return address; reset restarts the boot sequence.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      ret_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ret_addr_q <= ret_addr_d;
    end
  end

  assign pc           = pc_q;
  assign irq_ret_addr = ret_addr_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed table of per-cycle vectors followed by randomized
// traffic, every cycle compared against a behavioural model of the sequencer.
module tb_pc_seq;

  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          flush;
    logic          vec_rd;
    logic [AW-1:0] vec_addr;
    logic          irq_ack;
    logic          irq_push;
    logic [AW-1:0] ret;
  } out_t;

  typedef struct {
    logic          rst;
    logic          stall;
    logic          jmp;
    logic [AW-1:0] jt;
    logic          ret;
    logic [AW-1:0] rt;
    logic          irq;
    out_t          exp;
  } vec_t;

  typedef struct {
    logic [AW-1:0] val;
    bit            from_irq;
  } pend_t;

  logic          clk = 1'b0;
  logic          rst, stall, jmp_en, ret_en, irq;
  logic [AW-1:0] jmp_target, ret_target;
  logic          irq_ack, irq_push, vec_rd, pc_valid, flush;
  logic [AW-1:0] irq_ret_addr, vec_addr, pc;
  logic [AW-1:0] vec_data = '0;
  logic [AW-1:0] mem [0:1];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a boot request flag, a queue of vector words in flight,
  // and the architectural PC / saved return address.
  bit            m_boot;
  logic [AW-1:0] m_pc, m_ret;
  pend_t         m_pend [$];

  pc_seq #(.ADDR_W(AW), .RESET_VEC_ADDR(0), .IRQ_VEC_ADDR(1)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .jmp_en(jmp_en), .jmp_target(jmp_target),
    .ret_en(ret_en), .ret_target(ret_target),
    .irq(irq), .irq_ack(irq_ack), .irq_push(irq_push),
    .irq_ret_addr(irq_ret_addr), .vec_rd(vec_rd), .vec_addr(vec_addr),
    .vec_data(vec_data), .pc(pc), .pc_valid(pc_valid), .flush(flush)
  );

  always #5 clk = ~clk;

  // Vector memory with one cycle of read latency.
  always @(posedge clk) begin
    if (vec_rd) vec_data <= mem[vec_addr[0]];
  end

  task automatic check(input string name, input out_t act, input out_t exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got pc=%h v=%b fl=%b rd=%b va=%h ack=%b push=%b ret=%h, want pc=%h v=%b fl=%b rd=%b va=%h ack=%b push=%b ret=%h",
               name, act.pc, act.pc_valid, act.flush, act.vec_rd, act.vec_addr,
               act.irq_ack, act.irq_push, act.ret,
               exp.pc, exp.pc_valid, exp.flush, exp.vec_rd, exp.vec_addr,
               exp.irq_ack, exp.irq_push, exp.ret);
    end else begin
      n_pass++;
    end
  endtask

  // One clock cycle: predict outputs, compare mid-cycle, advance the model.
  task automatic cycle(input string name, input bit use_tab, input out_t tab_exp);
    out_t          exp, act;
    pend_t         item;
    logic [AW-1:0] target;
    bit            n_boot;
    logic [AW-1:0] n_pc, n_ret;

    @(negedge clk);
    exp    = '{pc: m_pc, pc_valid: 1'b0, flush: 1'b0, vec_rd: 1'b0, vec_addr: 8'h00,
               irq_ack: 1'b0, irq_push: 1'b0, ret: m_ret};
    n_boot = m_boot;
    n_pc   = m_pc;
    n_ret  = m_ret;
    if (m_boot) begin
      exp.vec_rd = 1'b1;
      n_boot     = 1'b0;
      m_pend.push_back('{val: mem[0], from_irq: 1'b0});
    end else if (m_pend.size() > 0) begin
      item      = m_pend.pop_front();
      exp.flush = item.from_irq;
      n_pc      = item.val;
    end else begin
      exp.pc_valid = 1'b1;
      target = ret_en ? ret_target : (jmp_en ? jmp_target : AW'((int'(m_pc) + 1) % 256));
      if (!stall) begin
        if (irq) begin
          exp.irq_ack  = 1'b1;
          exp.irq_push = 1'b1;
          exp.flush    = 1'b1;
          exp.vec_rd   = 1'b1;
          exp.vec_addr = 8'h01;
          n_ret        = target;
          m_pend.push_back('{val: mem[1], from_irq: 1'b1});
        end else begin
          n_pc      = target;
          exp.flush = jmp_en | ret_en;
        end
      end
    end
    if (rst) begin
      n_boot = 1'b1;
      n_pc   = '0;
      n_ret  = '0;
      m_pend.delete();
    end

    act = '{pc: pc, pc_valid: pc_valid, flush: flush, vec_rd: vec_rd, vec_addr: vec_addr,
            irq_ack: irq_ack, irq_push: irq_push, ret: irq_ret_addr};
    check({name, "/model"}, act, exp);
    if (use_tab) check({name, "/table"}, act, tab_exp);

    @(posedge clk);
    #1;
    m_boot = n_boot;
    m_pc   = n_pc;
    m_ret  = n_ret;
  endtask

  function automatic out_t e(input logic [7:0] p, input logic v, input logic fl,
                             input logic rd, input logic [7:0] va,
                             input logic ak, input logic ps, input logic [7:0] ra);
    return '{pc: p, pc_valid: v, flush: fl, vec_rd: rd, vec_addr: va,
             irq_ack: ak, irq_push: ps, ret: ra};
  endfunction

  function automatic vec_t v(input logic r, input logic s, input logic j, input logic [7:0] jt,
                             input logic rt_en, input logic [7:0] rt, input logic i, input out_t x);
    return '{rst: r, stall: s, jmp: j, jt: jt, ret: rt_en, rt: rt, irq: i, exp: x};
  endfunction

  vec_t tab [25];

  initial begin
    // Directed sequence: boot, wrap+stall, redirect priority, interrupts, reset in IRQ_WAIT.
    tab[0]  = v(0,0,0,8'h00,0,8'h00,0, e(8'h00,0,0,1,8'h00,0,0,8'h00)); // boot read
    tab[1]  = v(0,0,0,8'h00,0,8'h00,0, e(8'h00,0,0,0,8'h00,0,0,8'h00)); // boot wait
    tab[2]  = v(0,0,0,8'h00,0,8'h00,0, e(8'h40,1,0,0,8'h00,0,0,8'h00));
    tab[3]  = v(0,0,0,8'h00,0,8'h00,0, e(8'h41,1,0,0,8'h00,0,0,8'h00));
    tab[4]  = v(0,0,1,8'hFE,0,8'h00,0, e(8'h42,1,1,0,8'h00,0,0,8'h00));
    tab[5]  = v(0,0,0,8'h00,0,8'h00,0, e(8'hFE,1,0,0,8'h00,0,0,8'h00));
    tab[6]  = v(0,1,0,8'h00,0,8'h00,0, e(8'hFF,1,0,0,8'h00,0,0,8'h00));
    tab[7]  = v(0,1,1,8'h77,0,8'h00,0, e(8'hFF,1,0,0,8'h00,0,0,8'h00)); // jump ignored in stall
    tab[8]  = v(0,1,0,8'h00,0,8'h00,0, e(8'hFF,1,0,0,8'h00,0,0,8'h00));
    tab[9]  = v(0,0,0,8'h00,0,8'h00,0, e(8'hFF,1,0,0,8'h00,0,0,8'h00));
    tab[10] = v(0,0,1,8'h20,1,8'h30,0, e(8'h00,1,1,0,8'h00,0,0,8'h00)); // wrapped; ret beats jmp
    tab[11] = v(0,0,1,8'h20,0,8'h00,0, e(8'h30,1,1,0,8'h00,0,0,8'h00));
    tab[12] = v(0,0,1,8'h10,0,8'h00,0, e(8'h20,1,1,0,8'h00,0,0,8'h00));
    tab[13] = v(0,0,0,8'h00,0,8'h00,1, e(8'h10,1,1,1,8'h01,1,1,8'h00)); // irq accept
    tab[14] = v(0,0,0,8'h00,0,8'h00,1, e(8'h10,0,1,0,8'h00,0,0,8'h11)); // irq_wait
    tab[15] = v(0,0,0,8'h00,0,8'h00,0, e(8'h80,1,0,0,8'h00,0,0,8'h11));
    tab[16] = v(0,0,1,8'h55,0,8'h00,1, e(8'h81,1,1,1,8'h01,1,1,8'h11)); // irq + jump
    tab[17] = v(0,0,0,8'h00,0,8'h00,0, e(8'h81,0,1,0,8'h00,0,0,8'h55));
    tab[18] = v(0,1,0,8'h00,0,8'h00,1, e(8'h80,1,0,0,8'h00,0,0,8'h55)); // irq held off by stall
    tab[19] = v(0,1,0,8'h00,0,8'h00,1, e(8'h80,1,0,0,8'h00,0,0,8'h55));
    tab[20] = v(0,0,0,8'h00,0,8'h00,1, e(8'h80,1,1,1,8'h01,1,1,8'h55));
    tab[21] = v(1,0,0,8'h00,0,8'h00,0, e(8'h80,0,1,0,8'h00,0,0,8'h81)); // reset in irq_wait
    tab[22] = v(0,0,0,8'h00,0,8'h00,0, e(8'h00,0,0,1,8'h00,0,0,8'h00));
    tab[23] = v(0,0,0,8'h00,0,8'h00,0, e(8'h00,0,0,0,8'h00,0,0,8'h00));
    tab[24] = v(0,0,0,8'h00,0,8'h00,0, e(8'h40,1,0,0,8'h00,0,0,8'h00));

    mem[0] = 8'h40;
    mem[1] = 8'h80;
    rst = 1'b1; stall = 1'b0; jmp_en = 1'b0; ret_en = 1'b0; irq = 1'b0;
    jmp_target = '0; ret_target = '0;
    @(posedge clk);
    #1;
    m_boot = 1'b1;
    m_pc   = '0;
    m_ret  = '0;
    m_pend.delete();

    for (int k = 0; k < 25; k++) begin
      rst = tab[k].rst; stall = tab[k].stall; irq = tab[k].irq;
      jmp_en = tab[k].jmp; jmp_target = tab[k].jt;
      ret_en = tab[k].ret; ret_target = tab[k].rt;
      cycle($sformatf("vec%0d", k), 1'b1, tab[k].exp);
    end

    // Randomized traffic against the model, with occasional resets.
    mem[0] = 8'($urandom);
    mem[1] = 8'($urandom);
    for (int k = 0; k < 500; k++) begin
      rst        = ($urandom_range(0, 59) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      jmp_en     = ($urandom_range(0, 3) == 0);
      ret_en     = ($urandom_range(0, 5) == 0);
      irq        = ($urandom_range(0, 7) == 0);
      jmp_target = 8'($urandom);
      ret_target = 8'($urandom);
      cycle($sformatf("rnd%0d", k), 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
